// File: rtl/sram_bus_bridge_if.sv
// Bus bundle between the CPU/DMA masters, the arbitrating bridge and the SRAM controller port.
// Handshake: a master raises req (level) with we/addr/wdata stable and holds it until ack;
// ack is a one-cycle pulse, and for reads rdata is valid with ack and held until the next read.
interface sram_bus_bridge_if #(
    parameter int AW = 20
);
    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [7:0]    cpu_wdata;
    logic          cpu_ack;
    logic [7:0]    cpu_rdata;

    logic          dma_req;
    logic          dma_we;
    logic [AW-1:0] dma_addr;
    logic [7:0]    dma_wdata;
    logic          dma_ack;
    logic [7:0]    dma_rdata;

    logic          ram_ena;
    logic          ram_wea;
    logic [AW-1:0] ram_addr;
    logic [7:0]    ram_din;
    logic [7:0]    ram_dout;

    logic          busy;
    logic [1:0]    dbg_state;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_ack, cpu_rdata,
        input  dma_req, dma_we, dma_addr, dma_wdata,
        output dma_ack, dma_rdata,
        output ram_ena, ram_wea, ram_addr, ram_din,
        input  ram_dout,
        output busy, dbg_state
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_ack, cpu_rdata,
        output dma_req, dma_we, dma_addr, dma_wdata,
        input  dma_ack, dma_rdata,
        input  ram_ena, ram_wea, ram_addr, ram_din,
        output ram_dout,
        input  busy, dbg_state
    );
endinterface

// File: rtl/sram_bus_bridge.sv
// Two-master round-robin front end for the single-port SRAM controller: each grant becomes
// one fixed-length ena/wea/addr/din access followed by a registered one-cycle ack.
module sram_bus_bridge #(
    parameter int AW            = 20,
    parameter int ACCESS_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset,
    sram_bus_bridge_if.slave  bus
);
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_DONE   = 2'd2;

    localparam logic       GRANT_CPU = 1'b0;
    localparam logic       GRANT_DMA = 1'b1;
    localparam logic [3:0] CNT_LOAD  = 4'(ACCESS_CYCLES - 1);

    logic [1:0]    r_state;
    logic [3:0]    r_cnt;
    logic          r_last_grant;
    logic          r_grant;
    logic          r_is_write;
    logic          r_ram_ena;
    logic          r_ram_wea;
    logic [AW-1:0] r_ram_addr;
    logic [7:0]    r_ram_din;
    logic          r_cpu_ack;
    logic          r_dma_ack;
    logic [7:0]    r_cpu_rdata;
    logic [7:0]    r_dma_rdata;

    logic w_cpu_elig;
    logic w_dma_elig;
    logic w_pick_dma;

    // A master whose ack is high this cycle has not had a chance to drop req yet.
    assign w_cpu_elig = bus.cpu_req & ~r_cpu_ack;
    assign w_dma_elig = bus.dma_req & ~r_dma_ack;
    assign w_pick_dma = w_dma_elig & (~w_cpu_elig | (r_last_grant == GRANT_CPU));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_cnt        <= 4'd0;
            r_last_grant <= GRANT_DMA;
            r_grant      <= GRANT_CPU;
            r_is_write   <= 1'b0;
            r_ram_ena    <= 1'b0;
            r_ram_wea    <= 1'b0;
            r_ram_addr   <= '0;
            r_ram_din    <= 8'd0;
            r_cpu_ack    <= 1'b0;
            r_dma_ack    <= 1'b0;
            r_cpu_rdata  <= 8'd0;
            r_dma_rdata  <= 8'd0;
        end else begin
            r_cpu_ack <= 1'b0;
            r_dma_ack <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_cpu_elig || w_dma_elig) begin
                        r_grant      <= w_pick_dma;
                        r_last_grant <= w_pick_dma;
                        r_ram_ena    <= 1'b1;
                        r_ram_wea    <= w_pick_dma ? bus.dma_we    : bus.cpu_we;
                        r_is_write   <= w_pick_dma ? bus.dma_we    : bus.cpu_we;
                        r_ram_addr   <= w_pick_dma ? bus.dma_addr  : bus.cpu_addr;
                        r_ram_din    <= w_pick_dma ? bus.dma_wdata : bus.cpu_wdata;
                        r_cnt        <= CNT_LOAD;
                        r_state      <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    if (r_cnt == 4'd0) begin
                        r_ram_ena <= 1'b0;
                        r_ram_wea <= 1'b0;
                        r_state   <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_DONE: begin
                    // ram_dout now holds the data from the last enabled read edge.
                    if (r_grant == GRANT_DMA) begin
                        r_dma_ack <= 1'b1;
                        if (!r_is_write) r_dma_rdata <= bus.ram_dout;
                    end else begin
                        r_cpu_ack <= 1'b1;
                        if (!r_is_write) r_cpu_rdata <= bus.ram_dout;
                    end
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.ram_ena   = r_ram_ena;
    assign bus.ram_wea   = r_ram_wea;
    assign bus.ram_addr  = r_ram_addr;
    assign bus.ram_din   = r_ram_din;
    assign bus.cpu_ack   = r_cpu_ack;
    assign bus.cpu_rdata = r_cpu_rdata;
    assign bus.dma_ack   = r_dma_ack;
    assign bus.dma_rdata = r_dma_rdata;
    assign bus.busy      = (r_state != S_IDLE);
    assign bus.dbg_state = r_state;
endmodule

// File: tb/tb_sram_bus_bridge.sv
// Bench for sram_bus_bridge: table of single-master transactions, contention, held-req,
// mid-access reset, plus extra builds with ACCESS_CYCLES=1 and 5.
module tb_sram_bus_bridge;
    localparam int AW      = 20;
    localparam int MAIN_AC = 2;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    sram_bus_bridge_if #(.AW(AW)) bus ();
    sram_bus_bridge #(.AW(AW), .ACCESS_CYCLES(MAIN_AC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // ---------------- SRAM controller model (registered read data)
    logic [7:0] mem [logic [AW-1:0]];
    always @(posedge clk) begin
        if (bus.ram_ena) begin
            if (bus.ram_wea) mem[bus.ram_addr] = bus.ram_din;
            else bus.ram_dout <= mem.exists(bus.ram_addr) ? mem[bus.ram_addr] : 8'h00;
        end
    end

    // ---------------- scoreboard / counters
    int n_vec = 0;
    int n_err = 0;
    logic [8:0] exp_q[$];   // {dma, rdata}
    bit side_done [2];

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h", name, act, exp);
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- access monitor
    typedef struct {
        int            width;
        logic [AW-1:0] addr;
        logic          wea;
        logic [7:0]    din;
        bit            stable;
    } acc_t;

    acc_t acc_q[$];
    acc_t cur;
    int   run = 0;
    bit   wea_bad = 0;
    int   cpu_ack_cnt = 0;
    int   dma_ack_cnt = 0;

    always @(negedge clk) begin
        if (bus.ram_wea && !bus.ram_ena) wea_bad = 1'b1;
        if (bus.cpu_ack) cpu_ack_cnt++;
        if (bus.dma_ack) dma_ack_cnt++;
        if (bus.ram_ena) begin
            if (run == 0) begin
                cur.addr   = bus.ram_addr;
                cur.wea    = bus.ram_wea;
                cur.din    = bus.ram_din;
                cur.stable = 1'b1;
            end else if (bus.ram_addr !== cur.addr || bus.ram_wea !== cur.wea ||
                         bus.ram_din !== cur.din) begin
                cur.stable = 1'b0;
            end
            run++;
        end else if (run != 0) begin
            cur.width = run;
            acc_q.push_back(cur);
            run = 0;
        end
    end

    // ---------------- driver tasks
    task automatic drive_req(input bit dma, input bit we, input logic [AW-1:0] addr,
                             input logic [7:0] wdata);
        if (dma) begin
            bus.dma_req = 1'b1; bus.dma_we = we; bus.dma_addr = addr; bus.dma_wdata = wdata;
        end else begin
            bus.cpu_req = 1'b1; bus.cpu_we = we; bus.cpu_addr = addr; bus.cpu_wdata = wdata;
        end
    endtask

    task automatic wait_ack(input bit dma, output int lat, output bit got);
        lat = 0;
        got = 1'b0;
        while (!got && lat < 40) begin
            tick();
            lat++;
            got = dma ? bus.dma_ack : bus.cpu_ack;
        end
    endtask

    task automatic check_ack_data(input string tag, input bit dma, input bit got);
        logic [8:0] exp;
        exp = (exp_q.size() != 0) ? exp_q.pop_front() : 9'h1FF;
        if (!got) check({tag, " ack seen"}, 0, 1);
        else check({tag, " rdata"}, {dma, dma ? bus.dma_rdata : bus.cpu_rdata}, exp);
    endtask

    task automatic do_txn(input string tag, input bit dma, input bit we,
                          input logic [AW-1:0] addr, input logic [7:0] wdata,
                          input logic [7:0] exp_rd);
        int lat;
        bit got;
        int cpu0;
        int dma0;
        acc_t a;
        cpu0 = cpu_ack_cnt;
        dma0 = dma_ack_cnt;
        exp_q.push_back({dma, exp_rd});
        drive_req(dma, we, addr, wdata);
        wait_ack(dma, lat, got);
        bus.cpu_req = 1'b0;
        bus.dma_req = 1'b0;
        check({tag, " latency"}, lat, MAIN_AC + 2);
        check_ack_data(tag, dma, got);
        tick();
        check({tag, " ack pulse"}, dma ? bus.dma_ack : bus.cpu_ack, 0);
        check({tag, " other ack"}, dma ? (cpu_ack_cnt - cpu0) : (dma_ack_cnt - dma0), 0);
        check({tag, " accesses"}, acc_q.size(), 1);
        if (acc_q.size() != 0) begin
            a = acc_q.pop_front();
            check({tag, " ena width"}, a.width, MAIN_AC);
            check({tag, " ram_addr"}, a.addr, addr);
            check({tag, " ram_wea"}, a.wea, we);
            check({tag, " stable"}, a.stable, 1);
            if (we) check({tag, " ram_din"}, a.din, wdata);
        end
        acc_q.delete();
    endtask

    // ---------------- vector table
    typedef struct {
        bit            dma;
        bit            we;
        logic [AW-1:0] addr;
        logic [7:0]    wdata;
        logic [7:0]    exp_rd;
    } vec_t;

    vec_t vecs [11];

    initial begin
        int lat;
        bit got;
        int c0;
        int n;
        int overlap;
        int low;
        int maxlow;
        int t;

        reset = 1'b1;
        bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = 8'h00;
        bus.dma_req = 1'b0; bus.dma_we = 1'b0; bus.dma_addr = '0; bus.dma_wdata = 8'h00;
        mem[20'h0F000] = 8'hA5;
        mem[20'hFFFFF] = 8'hC3;

        vecs[0]  = '{0, 0, 20'h0F000, 8'h00, 8'hA5};
        vecs[1]  = '{0, 1, 20'h00400, 8'h3C, 8'hA5};
        vecs[2]  = '{0, 0, 20'h00400, 8'h00, 8'h3C};
        vecs[3]  = '{1, 1, 20'h12345, 8'h5A, 8'hC3};
        vecs[4]  = '{1, 0, 20'h12345, 8'h00, 8'h5A};
        vecs[5]  = '{1, 0, 20'hFFFFF, 8'h00, 8'hC3};
        vecs[6]  = '{0, 1, 20'h00000, 8'hFF, 8'h3C};
        vecs[7]  = '{0, 0, 20'h00000, 8'h00, 8'hFF};
        vecs[8]  = '{0, 0, 20'hFFFFF, 8'h00, 8'hC3};
        vecs[9]  = '{1, 1, 20'h00400, 8'h81, 8'hC3};
        vecs[10] = '{0, 0, 20'h00400, 8'h00, 8'h81};

        // ---- reset state
        repeat (2) @(posedge clk);
        #1;
        check("reset busy", bus.busy, 0);
        check("reset state", bus.dbg_state, 0);
        check("reset ena/wea", {bus.ram_ena, bus.ram_wea}, 0);
        check("reset addr/din", {bus.ram_addr, bus.ram_din}, 0);
        check("reset acks", {bus.cpu_ack, bus.dma_ack}, 0);
        check("reset rdata", {bus.cpu_rdata, bus.dma_rdata}, 0);
        reset = 1'b0;
        tick();

        // ---- contention straight after reset: CPU, DMA, CPU, DMA
        exp_q.push_back({1'b0, 8'hA5});
        exp_q.push_back({1'b1, 8'hC3});
        exp_q.push_back({1'b0, 8'hA5});
        exp_q.push_back({1'b1, 8'hC3});
        drive_req(0, 0, 20'h0F000, 8'h00);
        drive_req(1, 0, 20'hFFFFF, 8'h00);
        n = 0; overlap = 0; low = 0; maxlow = 0; t = 0;
        while (n < 4 && t < 60) begin
            tick();
            t++;
            if (bus.cpu_ack && bus.dma_ack) overlap++;
            if (bus.cpu_ack || bus.dma_ack) begin
                n++;
                check($sformatf("contention ack %0d", n),
                      {bus.dma_ack, bus.dma_ack ? bus.dma_rdata : bus.cpu_rdata},
                      (exp_q.size() != 0) ? exp_q.pop_front() : 9'h1FF);
                if (n == 4) begin bus.cpu_req = 1'b0; bus.dma_req = 1'b0; end
            end
            if (n >= 1 && n < 4) begin
                if (!bus.busy) low++;
                else begin
                    if (low > maxlow) maxlow = low;
                    low = 0;
                end
            end
        end
        bus.cpu_req = 1'b0;
        bus.dma_req = 1'b0;
        check("contention acks", n, 4);
        check("contention overlap", overlap, 0);
        check("contention idle gap", maxlow, 1);
        check("contention accesses", acc_q.size(), 4);
        foreach (acc_q[i]) check($sformatf("contention width %0d", i), acc_q[i].width, MAIN_AC);
        repeat (3) tick();
        acc_q.delete();

        // ---- table of single-master transactions
        for (int i = 0; i < 11; i++) begin
            do_txn($sformatf("vec%0d", i), vecs[i].dma, vecs[i].we, vecs[i].addr,
                   vecs[i].wdata, vecs[i].exp_rd);
        end

        // ---- held req: exactly one extra access, not in the ack cycle
        c0 = cpu_ack_cnt;
        exp_q.push_back({1'b0, 8'hA5});
        exp_q.push_back({1'b0, 8'hA5});
        drive_req(0, 0, 20'h0F000, 8'h00);
        wait_ack(0, lat, got);
        check_ack_data("held first", 0, got);
        tick();
        check("held guard idle", bus.busy, 0);
        tick();
        check("held regrant", bus.busy, 1);
        bus.cpu_req = 1'b0;
        wait_ack(0, lat, got);
        check_ack_data("held second", 0, got);
        repeat (6) tick();
        check("held ack count", cpu_ack_cnt - c0, 2);
        check("held accesses", acc_q.size(), 2);
        acc_q.delete();

        // ---- reset in the second ACCESS cycle of a write
        c0 = cpu_ack_cnt;
        drive_req(0, 1, 20'h00800, 8'h77);
        tick();
        tick();
        check("abort pre ena/wea", {bus.ram_ena, bus.ram_wea}, 2'b11);
        reset = 1'b1;
        #1;
        check("abort ena/wea", {bus.ram_ena, bus.ram_wea}, 0);
        check("abort busy", bus.busy, 0);
        tick();
        reset = 1'b0;
        bus.cpu_req = 1'b0;
        repeat (6) tick();
        check("abort no ack", cpu_ack_cnt - c0, 0);
        check("abort rdata", bus.cpu_rdata, 0);
        acc_q.delete();
        do_txn("after abort", 0, 0, 20'h0F000, 8'h00, 8'hA5);

        check("wea only with ena", wea_bad, 0);

        // ---- wait for the alternate builds
        for (int i = 0; i < 200 && !(side_done[0] && side_done[1]); i++) tick();
        check("alt builds done", {side_done[0], side_done[1]}, 2'b11);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // ---------------- ACCESS_CYCLES = 1 and 5 builds
    for (genvar k = 0; k < 2; k++) begin : g_alt
        localparam int AC = (k == 0) ? 1 : 5;
        logic side_rst;
        sram_bus_bridge_if #(.AW(AW)) sbus ();
        sram_bus_bridge #(.AW(AW), .ACCESS_CYCLES(AC)) sdut (
            .clk   (clk),
            .reset (side_rst),
            .bus   (sbus)
        );

        always @(posedge clk) begin
            if (sbus.ram_ena && !sbus.ram_wea) sbus.ram_dout <= sbus.ram_addr[7:0] ^ 8'h5A;
        end

        initial begin
            int lat;
            int width;
            bit got;
            side_rst = 1'b1;
            sbus.cpu_req = 1'b0; sbus.cpu_we = 1'b0; sbus.cpu_addr = '0; sbus.cpu_wdata = 8'h00;
            sbus.dma_req = 1'b0; sbus.dma_we = 1'b0; sbus.dma_addr = '0; sbus.dma_wdata = 8'h00;
            repeat (2) @(posedge clk);
            #1;
            side_rst = 1'b0;
            tick();
            sbus.cpu_req  = 1'b1;
            sbus.cpu_addr = 20'hABC12;
            lat = 0;
            width = 0;
            got = 1'b0;
            while (!got && lat < 40) begin
                tick();
                lat++;
                if (sbus.ram_ena) width++;
                got = sbus.cpu_ack;
            end
            sbus.cpu_req = 1'b0;
            check($sformatf("ac%0d latency", AC), lat, AC + 2);
            check($sformatf("ac%0d ena width", AC), width, AC);
            check($sformatf("ac%0d rdata", AC), sbus.cpu_rdata, 8'h48);
            side_done[k] = 1'b1;
        end
    end
endmodule

// File: doc/sram_bus_bridge.md
Name: sram_bus_bridge

Overview:
Two-master front end for the single-port SRAM controller. It accepts byte read/write requests from the CPU bus and the DMA engine and arbitrates between them. Each granted request becomes one fixed-length access on the controller's ena/wea/addr/din/dout port. Each master gets a one-cycle ack, and read data is returned registered with that ack.

Parameters:
AW, 20, byte address width; matches the SRAM controller address width.
ACCESS_CYCLES, 2, cycles ram_ena is held per access (legal range 1..15); covers external SRAM settle time.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
cpu_req  in  1  CPU request, level; held until cpu_ack
cpu_we  in  1  CPU write (1) / read (0); stable while cpu_req high
cpu_addr  in  AW  CPU byte address
cpu_wdata  in  8  CPU write data
cpu_ack  out  1  one-cycle completion pulse to CPU
cpu_rdata  out  8  CPU read data, valid in the cpu_ack cycle and held until the next CPU read completes
dma_req, dma_we, dma_addr, dma_wdata  in  1/1/AW/8  DMA request set; same rules as CPU
dma_ack  out  1  one-cycle completion pulse to DMA
dma_rdata  out  8  DMA read data; same rules as cpu_rdata
ram_ena  out  1  controller enable
ram_wea  out  1  controller write enable
ram_addr  out  AW  controller address
ram_din  out  8  controller write data
ram_dout  in  8  controller registered read data
busy  out  1  high whenever state is not IDLE

Behaviour:
- Reset (asynchronous, immediate): state=IDLE; ram_ena=0; ram_wea=0; ram_addr=0; ram_din=0; cpu_ack=dma_ack=0; cpu_rdata=dma_rdata=0; last_grant=DMA, so the CPU wins the first contention.
- All outputs are registered. There are no combinational paths from inputs to outputs.
- State machine has three states: IDLE, ACCESS, DONE.
- IDLE:
  - A master is eligible if its req=1 and its ack is not high in the current cycle. This guard prevents re-servicing a req the master has not yet dropped.
  - One eligible master: grant it.
  - Both eligible: grant the master not equal to last_grant (round-robin), then update last_grant.
  - On grant: latch we/addr/wdata into ram_wea/ram_addr/ram_din, set ram_ena=1, load cnt=ACCESS_CYCLES-1, go to ACCESS.
- ACCESS:
  - ram_ena=1 with ram_wea/ram_addr/ram_din held constant.
  - If cnt=0: ram_ena<=0, ram_wea<=0, go to DONE. Otherwise cnt decrements.
  - ram_ena is therefore high for exactly ACCESS_CYCLES cycles.
- DONE:
  - One cycle. ram_dout now reflects the last enabled read edge.
  - On the exiting edge: the granted master's ack<=1 and, for reads, its rdata<=ram_dout. Writes leave rdata unchanged. Return to IDLE.
- Latency: req sampled high at edge 0 gives ack high during the cycle after edge ACCESS_CYCLES+2. With the default that is edge 4, a 4-clock round trip. Reads and writes have identical latency.
- Back-to-back: the earliest next grant is the IDLE cycle in which ack is high, for the other master only. The same master needs req low or a fresh request one cycle later.
- Requests change only in IDLE. Changes to req/addr/we/wdata during ACCESS/DONE are ignored. A req dropped before ack does not abort; the access completes and ack still pulses.
- ram_wea is never high while ram_ena is low.
- Reset mid-access aborts immediately and no ack is issued. A partial SRAM write may occur; software owns that.
- Address and data are passed unmodified at width AW/8. No wrap or translation.

Test Plan:
- CPU read, default params: ram_dout model returns 8'hA5 for addr 20'h0F000 → ram_ena high exactly 2 cycles with ram_addr=20'h0F000 and ram_wea=0; cpu_ack is a single pulse 4 cycles after req; cpu_rdata=8'hA5; dma_ack never fires.
- CPU write: cpu_we=1, addr 20'h00400, wdata 8'h3C → ram_ena=ram_wea=1 for 2 cycles with ram_din=8'h3C; cpu_ack after 4 cycles; cpu_rdata unchanged from its previous value.
- Simultaneous cpu_req and dma_req held high after reset:
  - Grants alternate CPU, DMA, CPU, DMA.
  - Acks never overlap.
  - busy drops for exactly one IDLE cycle between accesses at most.
- Held req: CPU keeps req high for 2 cycles after its ack → the bridge performs exactly one extra access, not two; the ack-cycle guard is verified.
- Reset asserted in the second ACCESS cycle → ram_ena, ram_wea and busy go 0 asynchronously before the next edge; no ack. A following CPU read completes normally.
- ACCESS_CYCLES=1 and =5 builds: ram_ena pulse width is 1/5 cycles; ack latency is 3/7 cycles; read data is correct.
